// File: rtl/freq_meter.sv
// Measures the average period and the last high time of an asynchronous test
// signal, counted in CLK_in cycles over 2^AVG_LOG2 periods.
`timescale 1ns/1ps
module freq_meter #(
   parameter int CNT_W    = 16,
   parameter int AVG_LOG2 = 2,
   parameter int TIMEOUT  = 1000
) (
   input  logic             CLK_in,
   input  logic             RST,
   input  logic             SIG_in,
   input  logic             START,
   output logic             BUSY,
   output logic [CNT_W-1:0] PERIOD,
   output logic [CNT_W-1:0] HIGH_CNT,
   output logic             VALID,
   output logic             TIMEOUT_ERR
);

   localparam int TOT_W = CNT_W + AVG_LOG2;
   localparam int PC_W  = AVG_LOG2 + 1;
   localparam logic [PC_W-1:0]  PER_N = PC_W'(1) << AVG_LOG2;
   localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEAS, S_DONE} state_t;

   state_t           r_state, w_next;
   logic [2:0]       r_sync;
   logic [TOT_W-1:0] r_total;
   logic [CNT_W-1:0] r_hi;
   logic [PC_W-1:0]  r_per;
   logic [CNT_W-1:0] r_wd;
   logic [CNT_W-1:0] r_period;
   logic [CNT_W-1:0] r_high;
   logic             r_terr;

   logic             w_edge;
   logic [TOT_W-1:0] w_total_inc;
   logic [PC_W-1:0]  w_per_inc;
   logic             w_last;
   logic             w_tmo_hit;

   // r_sync[0..2] are s1..s3; the rising edge is seen between s2 and s3
   assign w_edge      = r_sync[1] & ~r_sync[2];
   assign w_total_inc = (&r_total) ? r_total : r_total + TOT_W'(1);
   assign w_per_inc   = r_per + PC_W'(1);
   assign w_last      = w_edge && (w_per_inc == PER_N);

   always_ff @(posedge CLK_in or posedge RST) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_tmo_hit = 1'b0;
      BUSY      = (r_state != S_IDLE);
      VALID     = (r_state == S_DONE);
      case (r_state)
         S_IDLE: if (START) w_next = S_ARM;
         S_ARM: begin
            if (w_edge) w_next = S_MEAS;
            else if (r_wd == TMO) begin
               w_next    = S_IDLE;
               w_tmo_hit = 1'b1;
            end
         end
         S_MEAS: begin
            if (w_last) w_next = S_DONE;
            else if (!w_edge && r_wd == TMO) begin
               w_next    = S_IDLE;
               w_tmo_hit = 1'b1;
            end
         end
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK_in or posedge RST) begin
      if (RST) begin
         r_sync   <= '0;
         r_total  <= '0;
         r_hi     <= '0;
         r_per    <= '0;
         r_wd     <= '0;
         r_period <= '0;
         r_high   <= '0;
         r_terr   <= 1'b0;
      end else begin
         r_sync <= {r_sync[1:0], SIG_in};
         r_terr <= w_tmo_hit;
         case (r_state)
            S_IDLE: if (START) r_wd <= '0;
            S_ARM: begin
               if (w_edge) begin
                  r_total <= '0;
                  r_hi    <= '0;
                  r_per   <= '0;
                  r_wd    <= '0;
               end else begin
                  r_wd <= r_wd + CNT_W'(1);
               end
            end
            S_MEAS: begin
               r_total <= w_total_inc;
               if (w_edge) begin
                  // s3 is always low on an edge cycle, so r_hi is final here
                  r_per <= w_per_inc;
                  r_wd  <= '0;
                  r_hi  <= '0;
                  if (w_last) begin
                     r_period <= w_total_inc[TOT_W-1:AVG_LOG2];
                     r_high   <= r_hi;
                  end
               end else begin
                  r_wd <= r_wd + CNT_W'(1);
                  if (r_sync[2]) r_hi <= r_hi + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign PERIOD      = r_period;
   assign HIGH_CNT    = r_high;
   assign TIMEOUT_ERR = r_terr;

endmodule

// File: tb/tb_freq_meter.sv
// Drives SIG_in as a list of high/low phase lengths and predicts PERIOD as the
// mean of the first 2^AVG_LOG2 full periods and HIGH_CNT as the last high phase.
`timescale 1ns/1ps
module tb_freq_meter;

   logic        CLK_in = 1'b0;
   logic        RST, SIG_in, START;
   logic        BUSY, VALID, TIMEOUT_ERR;
   logic [15:0] PERIOD, HIGH_CNT;

   freq_meter #(.CNT_W(16), .AVG_LOG2(2), .TIMEOUT(1000)) u_dut (
      .CLK_in      (CLK_in),
      .RST         (RST),
      .SIG_in      (SIG_in),
      .START       (START),
      .BUSY        (BUSY),
      .PERIOD      (PERIOD),
      .HIGH_CNT    (HIGH_CNT),
      .VALID       (VALID),
      .TIMEOUT_ERR (TIMEOUT_ERR)
   );

   always #5 CLK_in = ~CLK_in;

   int          n_chk = 0, n_fail = 0;
   int          n_valid = 0, n_terr = 0;
   logic [15:0] got_p, got_h;
   logic [15:0] exp_p = '0, exp_h = '0;
   logic        vld_d = 1'b0;
   int          hh[5], ll[5];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   always @(negedge CLK_in) begin
      if (vld_d) begin
         chk("valid_width", {31'd0, VALID}, 32'd0);
         chk("busy_after_valid", {31'd0, BUSY}, 32'd0);
      end
      if (VALID) begin
         n_valid++;
         got_p = PERIOD;
         got_h = HIGH_CNT;
         chk("busy_at_valid", {31'd0, BUSY}, 32'd1);
      end
      if (TIMEOUT_ERR) n_terr++;
      vld_d = VALID;
   end

   // mode 0: plain run, 1: extra START pulses mid-run, 2: reset mid-run
   task automatic run_meas(input int mode);
      int          v0, t0, sum;
      logic [15:0] ep, eh;
      sum = 0;
      for (int i = 0; i < 4; i++) sum += hh[i] + ll[i];
      ep = 16'(sum / 4);
      eh = 16'(hh[3]);
      SIG_in = 1'b0;
      repeat (4) @(negedge CLK_in);
      chk("idle_busy", {31'd0, BUSY}, 32'd0);
      v0 = n_valid;
      t0 = n_terr;
      START = 1'b1;
      @(negedge CLK_in);
      START = 1'b0;
      chk("start_busy", {31'd0, BUSY}, 32'd1);
      repeat (2) @(negedge CLK_in);
      for (int i = 0; i < 5; i++) begin
         if (mode == 2 && i == 2) begin
            RST = 1'b1;
            #1;
            chk("rst_busy", {31'd0, BUSY}, 32'd0);
            chk("rst_period", {16'd0, PERIOD}, 32'd0);
            chk("rst_high", {16'd0, HIGH_CNT}, 32'd0);
            chk("rst_valid", {31'd0, VALID}, 32'd0);
            chk("rst_terr", {31'd0, TIMEOUT_ERR}, 32'd0);
            repeat (2) @(negedge CLK_in);
            RST = 1'b0;
            repeat (3) @(negedge CLK_in);
            chk("rst_no_valid", n_valid - v0, 32'd0);
            chk("rst_no_terr", n_terr - t0, 32'd0);
            chk("rst_idle", {31'd0, BUSY}, 32'd0);
            exp_p = '0;
            exp_h = '0;
            return;
         end
         SIG_in = 1'b1;
         if (mode == 1) begin
            START = 1'b1;
            @(negedge CLK_in);
            START = 1'b0;
            repeat (hh[i] - 1) @(negedge CLK_in);
         end else begin
            repeat (hh[i]) @(negedge CLK_in);
         end
         SIG_in = 1'b0;
         repeat (ll[i]) @(negedge CLK_in);
      end
      for (int k = 0; k < 40 && BUSY; k++) @(negedge CLK_in);
      chk("done_idle", {31'd0, BUSY}, 32'd0);
      @(negedge CLK_in);
      chk("valid_count", n_valid - v0, 32'd1);
      chk("terr_count", n_terr - t0, 32'd0);
      chk("period_at_valid", {16'd0, got_p}, {16'd0, ep});
      chk("high_at_valid", {16'd0, got_h}, {16'd0, eh});
      chk("period_hold", {16'd0, PERIOD}, {16'd0, ep});
      chk("high_hold", {16'd0, HIGH_CNT}, {16'd0, eh});
      exp_p = ep;
      exp_h = eh;
   endtask

   task automatic set_wave(input int h, input int l);
      for (int i = 0; i < 5; i++) begin
         hh[i] = h;
         ll[i] = l;
      end
   endtask

   task automatic run_timeout();
      int cyc, v0;
      SIG_in = 1'b0;
      repeat (4) @(negedge CLK_in);
      v0 = n_valid;
      START = 1'b1;
      @(negedge CLK_in);
      START = 1'b0;
      cyc = 1;
      while (!TIMEOUT_ERR && cyc < 1200) begin
         @(negedge CLK_in);
         cyc++;
      end
      chk("tmo_seen", {31'd0, TIMEOUT_ERR}, 32'd1);
      chk("tmo_latency_ok", {31'd0, (cyc >= 1000 && cyc <= 1003)}, 32'd1);
      chk("tmo_busy", {31'd0, BUSY}, 32'd0);
      chk("tmo_period", {16'd0, PERIOD}, {16'd0, exp_p});
      chk("tmo_high", {16'd0, HIGH_CNT}, {16'd0, exp_h});
      @(negedge CLK_in);
      chk("tmo_pulse", {31'd0, TIMEOUT_ERR}, 32'd0);
      chk("tmo_no_valid", n_valid - v0, 32'd0);
   endtask

   initial begin
      RST = 1'b1;
      START = 1'b0;
      SIG_in = 1'b0;
      repeat (3) @(negedge CLK_in);
      chk("reset_busy", {31'd0, BUSY}, 32'd0);
      chk("reset_period", {16'd0, PERIOD}, 32'd0);
      chk("reset_high", {16'd0, HIGH_CNT}, 32'd0);
      chk("reset_valid", {31'd0, VALID}, 32'd0);
      chk("reset_terr", {31'd0, TIMEOUT_ERR}, 32'd0);
      RST = 1'b0;
      repeat (2) @(negedge CLK_in);

      set_wave(5, 5);   run_meas(0);
      set_wave(50, 50); run_meas(0);
      set_wave(1, 1);   run_meas(0);
      for (int i = 0; i < 5; i++) begin
         hh[i] = (i % 2 == 0) ? 4 : 5;
         ll[i] = (i % 2 == 0) ? 5 : 6;
      end
      run_meas(0);
      run_timeout();
      set_wave(7, 3);   run_meas(1);
      set_wave(8, 8);   run_meas(2);
      set_wave(6, 6);   run_meas(0);
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 5; i++) begin
            hh[i] = int'($urandom_range(1, 40));
            ll[i] = int'($urandom_range(1, 40));
         end
         run_meas(0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

endmodule

// File: doc/freq_meter.md
# freq_meter

Frequency/period measurement block; the receive-side counterpart of the clock divider. It takes an asynchronous test clock (e.g. a divided CLK_10 or CLK_1 output) and measures that signal against CLK_in. It reports the average period, in CLK_in cycles, over 2^AVG_LOG2 periods, plus the high time of the last measured period. It is used in self-test, to confirm that divider outputs have the expected ratio and duty.

## Interface
- CNT_W, 16: width of PERIOD, HIGH_CNT and the watchdog counter.
- AVG_LOG2, 2: number of periods averaged per measurement is 2^AVG_LOG2.
- TIMEOUT, 1000: number of CLK_in cycles without a SIG_in rising edge before the measurement aborts. Must be < 2^CNT_W.

Ports:
- CLK_in  in  1  sole clock; every flop is on posedge CLK_in.
- RST  in  1  asynchronous, active-high reset.
- SIG_in  in  1  signal under test; asynchronous to CLK_in.
- START  in  1  single-cycle request; sampled only in IDLE.
- BUSY  out  1  high in ARM, MEAS and DONE.
- PERIOD  out  CNT_W  average period in CLK_in cycles; holds its value until the next VALID.
- HIGH_CNT  out  CNT_W  high time of the final measured period.
- VALID  out  1  one-cycle pulse when PERIOD/HIGH_CNT update.
- TIMEOUT_ERR  out  1  one-cycle pulse on abort.

## Operation
- Synchronizer: three flops s1→s2→s3 on SIG_in.
  - Edge pulse: edge = s2 & ~s3.
  - Latency from SIG_in rise to edge is 2–3 cycles. This latency is constant, so it does not bias the counts.
- FSM states: IDLE, ARM, MEAS, DONE.
- IDLE
  - START=1 → ARM; clear the watchdog.
- ARM
  - Wait for the first edge.
  - On edge → MEAS; clear total, hi_cnt, per_cnt and the watchdog.
- MEAS, every cycle:
  - total += 1; total is CNT_W+AVG_LOG2 bits wide and saturates at all-ones.
  - hi_cnt += 1 when s3=1.
  - watchdog += 1.
- MEAS, on edge:
  - per_cnt += 1; clear the watchdog; clear hi_cnt after sampling it.
  - If per_cnt reaches 2^AVG_LOG2: PERIOD <= total_after_increment >> AVG_LOG2; HIGH_CNT <= hi_cnt; go to DONE.
- DONE
  - VALID=1 for exactly this cycle, then go to IDLE.
- Watchdog
  - In ARM or MEAS, when the watchdog reaches TIMEOUT: TIMEOUT_ERR=1 for one cycle, enter IDLE, PERIOD/HIGH_CNT unchanged, VALID not asserted.
  - If an edge and the timeout occur in the same cycle, the edge wins.
- Saturation: if total saturates, PERIOD = all-ones.
- START while BUSY is ignored. No queueing.
- Measurement window: P cycles between edges accumulate exactly P into total, since the increments cover the cycles after the opening edge up to and including the closing edge.

## Timing
- Reset values: BUSY=0, PERIOD=0, HIGH_CNT=0, VALID=0, TIMEOUT_ERR=0, FSM=IDLE, s1/s2/s3=0, all counters 0.
- RST asserted mid-measurement: immediate return to the reset values. No VALID or TIMEOUT_ERR is generated.
- START at cycle n → BUSY=1 at n+1.
- Final edge at cycle m → PERIOD/HIGH_CNT updated and VALID=1 at m+1; BUSY=0 at m+2.
- Timeout: TIMEOUT_ERR is asserted in the cycle after the watchdog reaches TIMEOUT; BUSY drops in that same cycle.
- Minimum measurable period is 2 cycles. SIG_in high or low for less than 1 CLK_in cycle is not guaranteed to be seen.

## Test plan
- SIG_in = CLK_in/10 with 50% duty (5 high/5 low), AVG_LOG2=2, START → PERIOD=10, HIGH_CNT=5, VALID for 1 cycle; the measurement ends roughly 40–53 cycles after START.
- SIG_in = CLK_in/100 with 50% duty → PERIOD=100, HIGH_CNT=50. Then SIG_in = CLK_in/2 → PERIOD=2, HIGH_CNT=1.
- SIG_in held at 0, START, TIMEOUT=1000 → TIMEOUT_ERR pulse about 1001 cycles after START; PERIOD keeps its previous value; no VALID.
- START pulses while BUSY → ignored; exactly one VALID per accepted START.
- RST asserted mid-MEAS → all outputs 0 and IDLE. A new START after release measures correctly.
- Period alternating 9/11 cycles, AVG_LOG2=2 → PERIOD=10.
